// File: rtl/logic_gate_pkg.sv
// Shared types and helpers for the logic gate pipeline: op codes, FIFO depth
// and the per-bit reduction used to build each result.
package logic_gate_pkg;

   localparam int OP_W       = 3;
   localparam int FIFO_DEPTH = 2;
   localparam int MAX_IN     = 8;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_ILL6 = 3'd6,
      OP_ILL7 = 3'd7
   } op_e;

   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      return (op < 3'd6);
   endfunction

   // Reduces one bit column across the first num operands; the inverted ops
   // invert the full reduction rather than chaining two-input gates.
   function automatic logic reduce_column(input logic [OP_W-1:0] op,
                                          input logic [MAX_IN-1:0] col,
                                          input int num);
      logic r_and;
      logic r_or;
      logic r_xor;
      logic r;
      r_and = 1'b1;
      r_or  = 1'b0;
      r_xor = 1'b0;
      for (int i = 0; i < MAX_IN; i++) begin
         if (i < num) begin
            r_and = r_and & col[i];
            r_or  = r_or  | col[i];
            r_xor = r_xor ^ col[i];
         end
      end
      case (op_e'(op))
         OP_AND:  r = r_and;
         OP_OR:   r = r_or;
         OP_XOR:  r = r_xor;
         OP_NAND: r = ~r_and;
         OP_NOR:  r = ~r_or;
         OP_XNOR: r = ~r_xor;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_gate_fifo2.sv
// Two-entry FIFO holding result+flag words; head is the oldest entry and
// count is the number of stored entries.
module logic_gate_fifo2
   import logic_gate_pkg::*;
#(
   parameter int DW = 9,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem [FIFO_DEPTH];
   logic          wr_ptr;
   logic          rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Guard against overflow/underflow even if the caller misbehaves.
   assign do_push = push && (count < CW'(FIFO_DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise reduction over NUM_IN operands with a one-cycle registered result
// path through a two-entry output FIFO and a completed-transaction counter.
module logic_gate_pipe
   import logic_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2,
   parameter int CNT_W  = 16
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OP_W-1:0]         in_op,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic [CNT_W-1:0]        done_cnt
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("logic_gate_pipe: WIDTH must be in 1..64");
   end
   if (NUM_IN < 2 || NUM_IN > MAX_IN) begin : g_bad_num_in
      $error("logic_gate_pipe: NUM_IN must be in 2..8");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("logic_gate_pipe: CNT_W must be at least 1");
   end

   logic [WIDTH-1:0]  result;
   logic [MAX_IN-1:0] col;
   logic              err;
   logic              accept;
   logic              pop;
   logic              ready_en;
   logic [WIDTH:0]    head;
   logic [CW-1:0]     count;

   // Gather bit b of every operand into a column and reduce it.
   always_comb begin
      result = '0;
      col    = '0;
      for (int b = 0; b < WIDTH; b++) begin
         col = '0;
         for (int k = 0; k < NUM_IN; k++) begin
            col[k] = in_data[k*WIDTH + b];
         end
         result[b] = reduce_column(in_op, col, NUM_IN);
      end
   end

   assign err    = !op_is_legal(in_op);
   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   // Holds in_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   logic_gate_fifo2 #(
      .DW (WIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_data ({(err ? 1'b1 : 1'b0), (err ? '0 : result)}),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign in_ready  = ready_en && (count < CW'(FIFO_DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
   assign out_err   = out_valid && head[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= '0;
      end else if (pop) begin
         done_cnt <= done_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomised and directed scoreboard bench for logic_gate_pipe (NUM_IN=4,
// CNT_W=4 so counter wrap is reachable).
module tb_logic_gate_pipe;

   localparam int WIDTH  = 8;
   localparam int NUM_IN = 4;
   localparam int CNT_W  = 4;
   localparam int DW     = NUM_IN * WIDTH;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        in_op = '0;
   logic [DW-1:0]     in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  out_data;
   logic              out_err;
   logic [CNT_W-1:0]  done_cnt;

   int                total = 0;
   int                bad = 0;
   logic [WIDTH:0]    exp_q[$];
   int                exp_done = 0;
   bit                mon_en = 1'b0;
   bit                held = 1'b0;
   logic [WIDTH:0]    held_val = '0;
   bit                rand_phase = 1'b0;

   logic_gate_pipe #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Word-level reference: reduce whole operands, then invert for N-ops.
   function automatic logic [WIDTH:0] model(input logic [2:0] op, input logic [DW-1:0] d);
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] o;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] w;
      a = '1;
      o = '0;
      x = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         w = d[k*WIDTH +: WIDTH];
         a = a & w;
         o = o | w;
         x = x ^ w;
      end
      case (op)
         3'd0:    return {1'b0, a};
         3'd1:    return {1'b0, o};
         3'd2:    return {1'b0, x};
         3'd3:    return {1'b0, ~a};
         3'd4:    return {1'b0, ~o};
         3'd5:    return {1'b0, ~x};
         default: return {1'b1, {WIDTH{1'b0}}};
      endcase
   endfunction

   // Issues one transaction; starts and ends at posedge+1.
   task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 64'(in_ready), 64'(1));
      end else begin
         exp_q.push_back(model(op, d));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_op    = 'x;
      in_data  = 'x;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      exp_q.delete();
      exp_done = 0;
      held = 1'b0;
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_done_cnt", 64'(done_cnt), 64'(0));
      checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
      checkOutput("rst_out_data", 64'(out_data), 64'(0));
      checkOutput("rst_out_err", 64'(out_err), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("rel_in_ready_low", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      checkOutput("rel_in_ready_high", 64'(in_ready), 64'(1));
   endtask

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      logic [WIDTH:0] e;
      if (mon_en && rst_n) begin
         checkOutput("done_cnt", 64'(done_cnt), 64'(exp_done % (1 << CNT_W)));
         if (held && out_valid) begin
            checkOutput("hold_stable", 64'({out_err, out_data}), 64'(held_val));
         end
         held     = out_valid && !out_ready;
         held_val = {out_err, out_data};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_output", 64'(out_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               checkOutput("out_data", 64'(out_data), 64'(e[WIDTH-1:0]));
               checkOutput("out_err", 64'(out_err), 64'(e[WIDTH]));
               exp_done++;
            end
         end
      end
   end

   initial begin
      int gap;
      $display("[TB] start");
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      doReset();
      out_ready = 1'b1;

      // Directed functional vectors, checking one-cycle latency on the first.
      applyStimulus(3'd2, {8'h08, 8'h04, 8'h02, 8'h01});
      checkOutput("latency_valid", 64'(out_valid), 64'(1));
      checkOutput("latency_data", 64'(out_data), 64'(8'h0F));
      applyStimulus(3'd5, {8'h08, 8'h04, 8'h02, 8'h01});
      applyStimulus(3'd6, 32'hDEADBEEF);
      applyStimulus(3'd0, 32'hFFFF_FFFF);
      applyStimulus(3'd3, {8'hFF, 8'hFF, 8'h0F, 8'hFF});
      applyStimulus(3'd7, 32'h1234_5678);
      applyStimulus(3'd4, 32'h0000_0000);
      applyStimulus(3'd1, {8'h80, 8'h00, 8'h00, 8'h01});
      drain();

      // Backpressure: two accepted, third ignored while full.
      out_ready = 1'b0;
      applyStimulus(3'd1, 32'h0102_0408);
      applyStimulus(3'd2, 32'hF0F0_0F0F);
      checkOutput("full_in_ready", 64'(in_ready), 64'(0));
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_data  = 32'hAAAA_AAAA;
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("full_ignored", 64'(in_ready), 64'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("ready_after_pop", 64'(in_ready), 64'(1));
      out_ready = 1'b1;
      drain();

      // Reset with the FIFO full discards everything.
      out_ready = 1'b0;
      applyStimulus(3'd0, 32'h1111_1111);
      applyStimulus(3'd1, 32'h2222_2222);
      doReset();
      out_ready = 1'b1;
      applyStimulus(3'd3, {8'hFF, 8'hFF, 8'h0F, 8'hFF});
      drain();

      // Continuous stream: one result per cycle and counter wrap.
      doReset();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), $urandom);
         checkOutput("stream_valid", 64'(out_valid), 64'(1));
      end
      drain();
      checkOutput("wrap_done_cnt", 64'(done_cnt), 64'(1));

      // Randomised traffic with random consumer backpressure.
      rand_phase = 1'b1;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               applyStimulus(3'($urandom_range(0, 7)), $urandom);
               gap = $urandom_range(0, 2);
               if (gap > 0) begin
                  repeat (gap) @(posedge clk);
                  #1;
               end
            end
            rand_phase = 1'b0;
         end
         begin
            while (rand_phase) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result bit width (1..64).
REQ-002 Parameter NUM_IN, default 2, number of operands per transaction (2..8).
REQ-003 Parameter CNT_W, default 16, width of the completed-transaction counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand set and op are valid.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 in_op  input  3  operation code, defined in REQ-013.
REQ-009 in_data  input  NUM_IN*WIDTH  packed operands; operand k is bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  result at FIFO head is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  WIDTH  result; out_err  output  1  illegal-op flag for that result; done_cnt  output  CNT_W  completed transactions.

Function
REQ-013 in_op codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 are illegal.
REQ-014 Result is the bitwise reduction over all NUM_IN operands; NAND/NOR/XNOR are the inversion of the full AND/OR/XOR reduction, not a chained pairwise gate.
REQ-015 Illegal op: the result is all-zero and the entry's out_err is 1; legal op: out_err is 0.
REQ-016 Input accept occurs when in_valid && in_ready are both high at the rising edge; output handshake occurs when out_valid && out_ready are both high.
REQ-017 The computed result and err flag are written into a 2-entry output FIFO on the accept edge.
REQ-018 Latency is 1 cycle: out_valid is high in the cycle after accept when the FIFO was empty.
REQ-019 out_valid = (count != 0); out_data and out_err present the FIFO head and stay stable while out_valid && !out_ready.
REQ-020 in_ready = (count < 2), decoded from registered state only; it has no combinational path from out_ready.
REQ-021 Simultaneous accept and pop at count 1: count stays 1, the new entry follows the popped one, and there is no bubble.
REQ-022 At count 2, in_ready is 0 and in_valid is ignored; a pop drops count to 1 and in_ready rises the next cycle.
REQ-023 Ordering is strict FIFO and no entry is ever dropped or duplicated.
REQ-024 done_cnt increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
REQ-025 in_data and in_op are don't-care when in_valid is low; X on them shall not propagate into state.

Reset
REQ-026 While rst_n is low: count=0, FIFO pointers=0, out_valid=0, out_data=0, out_err=0, done_cnt=0, in_ready=0.
REQ-027 in_ready rises in the first clock cycle after rst_n deasserts.
REQ-028 Reset asserted mid-operation discards all FIFO contents immediately (asynchronously), and no handshake completes in that cycle.

Structure
REQ-029 Package logic_gate_pkg holds the op_e enum (REQ-013 codes), OP_W=3, FIFO_DEPTH=2, and the reduction function.
REQ-030 Sub-module logic_gate_fifo2 implements the parametrised 2-entry FIFO (data width WIDTH+1) with count, push, pop and head outputs.
REQ-031 Parameter legality (WIDTH, NUM_IN ranges) is checked at elaboration and fails the build if violated.

Verification
REQ-032 WIDTH=8, NUM_IN=2, op=3, data {0xFF,0x0F}, out_ready=1 -> next cycle out_data=0xF0, out_err=0, done_cnt=1.
REQ-033 NUM_IN=4, op=2, data {0x01,0x02,0x04,0x08} -> out_data=0x0F; op=5 with the same data -> out_data=0xF0.
REQ-034 op=6, any data -> out_data=0x00, out_err=1; the next legal op has out_err=0.
REQ-035 out_ready=0, three back-to-back valids -> two accepted, in_ready=0 on the third; after out_ready=1, results emerge in order with no loss.
REQ-036 Continuous valid with out_ready=1 -> one result per cycle; with CNT_W=4, after 17 handshakes done_cnt=1.
REQ-037 rst_n pulsed low with count=2 -> out_valid=0, done_cnt=0 immediately; the first post-reset transaction returns the correct result.
